// File: rtl/ecc_op_dispatcher_pkg.sv
// Shared types and constants for the ECC operation dispatcher.
// Op codes, FSM states, config register map and response status codes.
package ecc_op_dispatcher_pkg;

  typedef enum logic [1:0] {
    OP_PMULT = 2'd0,
    OP_PADD  = 2'd1,
    OP_MMUL  = 2'd2,
    OP_MINV  = 2'd3
  } ecc_op_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_RESP   = 2'd3
  } disp_state_t;

  localparam logic [3:0] CFG_P  = 4'd0;
  localparam logic [3:0] CFG_A  = 4'd1;
  localparam logic [3:0] CFG_B  = 4'd2;
  localparam logic [3:0] CFG_N  = 4'd3;
  localparam logic [3:0] CFG_GX = 4'd4;
  localparam logic [3:0] CFG_GY = 4'd5;
  localparam int CFG_NUM_REGS = 6;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;

endpackage

// File: rtl/ecc_cfg_regfile.sv
// Curve-parameter register file: writes locked while the dispatcher is busy.
// Rejected writes (locked or out-of-range index) raise a one-cycle error pulse.
module ecc_cfg_regfile
  import ecc_op_dispatcher_pkg::*;
#(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [3:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             lock,
  output logic             wr_err,
  output logic [WIDTH-1:0] cfg_p,
  output logic [WIDTH-1:0] cfg_a,
  output logic [WIDTH-1:0] cfg_b,
  output logic [WIDTH-1:0] cfg_n,
  output logic [WIDTH-1:0] cfg_gx,
  output logic [WIDTH-1:0] cfg_gy
);

  logic [WIDTH-1:0] p_q, p_d, a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] n_q, n_d, gx_q, gx_d, gy_q, gy_d;
  logic             err_q, err_d;
  logic             bad;

  assign bad = lock || (addr >= 4'(CFG_NUM_REGS));

  always_comb begin
    p_d   = p_q;
    a_d   = a_q;
    b_d   = b_q;
    n_d   = n_q;
    gx_d  = gx_q;
    gy_d  = gy_q;
    err_d = 1'b0;
    if (wr_en && bad) begin
      err_d = 1'b1;
    end else if (wr_en) begin
      unique case (1'b1)
        (addr == CFG_P):  p_d  = wdata;
        (addr == CFG_A):  a_d  = wdata;
        (addr == CFG_B):  b_d  = wdata;
        (addr == CFG_N):  n_d  = wdata;
        (addr == CFG_GX): gx_d = wdata;
        (addr == CFG_GY): gy_d = wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      n_q   <= '0;
      gx_q  <= '0;
      gy_q  <= '0;
      err_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      a_q   <= a_d;
      b_q   <= b_d;
      n_q   <= n_d;
      gx_q  <= gx_d;
      gy_q  <= gy_d;
      err_q <= err_d;
    end
  end

  assign wr_err = err_q;
  assign cfg_p  = p_q;
  assign cfg_a  = a_q;
  assign cfg_b  = b_q;
  assign cfg_n  = n_q;
  assign cfg_gx = gx_q;
  assign cfg_gy = gy_q;

endmodule

// File: rtl/ecc_op_dispatcher.sv
// ECC command dispatcher: launches one external engine per command via Reset/Done.
// Optional watchdog on the RUN state: define ECC_DISPATCH_TIMEOUT_EN.
module ecc_op_dispatcher
  import ecc_op_dispatcher_pkg::*;
#(
  parameter int WIDTH          = 256,
  parameter int NUM_OPS        = 4,
  parameter int TIMEOUT_CYCLES = 2097152
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_wr_en,
  input  logic [3:0]               cfg_addr,
  input  logic [WIDTH-1:0]         cfg_wdata,
  output logic                     cfg_wr_err,
  output logic [WIDTH-1:0]         cfg_p,
  output logic [WIDTH-1:0]         cfg_a,
  output logic [WIDTH-1:0]         cfg_b,
  output logic [WIDTH-1:0]         cfg_n,
  output logic [WIDTH-1:0]         cfg_gx,
  output logic [WIDTH-1:0]         cfg_gy,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [WIDTH-1:0]         cmd_ax,
  input  logic [WIDTH-1:0]         cmd_ay,
  input  logic [WIDTH-1:0]         cmd_bx,
  input  logic [WIDTH-1:0]         cmd_by,
  input  logic [WIDTH-1:0]         cmd_k,
  output logic [WIDTH-1:0]         opnd_ax,
  output logic [WIDTH-1:0]         opnd_ay,
  output logic [WIDTH-1:0]         opnd_bx,
  output logic [WIDTH-1:0]         opnd_by,
  output logic [WIDTH-1:0]         opnd_k,
  output logic [NUM_OPS-1:0]       eng_rst,
  input  logic [NUM_OPS-1:0]       eng_done,
  input  logic [NUM_OPS*WIDTH-1:0] eng_res_x,
  input  logic [NUM_OPS*WIDTH-1:0] eng_res_y,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_x,
  output logic [WIDTH-1:0]         rsp_y,
  output logic [1:0]               rsp_status,
  output logic                     busy
);

  disp_state_t      state_q, state_d;
  ecc_op_t          op_q, op_d;
  logic [WIDTH-1:0] ax_q, ax_d, ay_q, ay_d, bx_q, bx_d;
  logic [WIDTH-1:0] by_q, by_d, k_q, k_d;
  logic [WIDTH-1:0] rx_q, rx_d, ry_q, ry_d;
  logic [1:0]       st_q, st_d;
  logic [WIDTH-1:0] res_x, res_y;
  logic             done_sel, is_scalar, tmo;
  logic [1:0]       op_idx;

  ecc_cfg_regfile #(.WIDTH(WIDTH)) u_cfg (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (cfg_wr_en),
    .addr   (cfg_addr),
    .wdata  (cfg_wdata),
    .lock   (busy),
    .wr_err (cfg_wr_err),
    .cfg_p  (cfg_p),
    .cfg_a  (cfg_a),
    .cfg_b  (cfg_b),
    .cfg_n  (cfg_n),
    .cfg_gx (cfg_gx),
    .cfg_gy (cfg_gy)
  );

  assign op_idx    = op_q;
  assign is_scalar = (op_q == OP_MMUL) || (op_q == OP_MINV);

  // Select the running engine's done and result slot
  always_comb begin
    res_x    = '0;
    res_y    = '0;
    done_sel = 1'b0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (op_idx == 2'(i)) begin
        res_x    = eng_res_x[i*WIDTH +: WIDTH];
        res_y    = eng_res_y[i*WIDTH +: WIDTH];
        done_sel = eng_done[i];
      end
    end
  end

`ifdef ECC_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt_q, cnt_d;

  // Fires in the RUN cycle in which the count reaches the limit
  assign tmo = (cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_LAUNCH) begin
      cnt_d = '0;
    end else if (state_q == S_RUN) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ax_d    = ax_q;
    ay_d    = ay_q;
    bx_d    = bx_q;
    by_d    = by_q;
    k_d     = k_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    st_d    = st_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = ecc_op_t'(cmd_op);
          ax_d    = cmd_ax;
          ay_d    = cmd_ay;
          bx_d    = cmd_bx;
          by_d    = cmd_by;
          k_d     = cmd_k;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_RUN;
      S_RUN: begin
        if (done_sel) begin
          rx_d    = res_x;
          ry_d    = is_scalar ? '0 : res_y;
          st_d    = ST_OK;
          state_d = S_RESP;
        end else if (tmo) begin
          rx_d    = '0;
          ry_d    = '0;
          st_d    = ST_TIMEOUT;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_PMULT;
      ax_q    <= '0;
      ay_q    <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      k_q     <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      st_q    <= ST_OK;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      k_q     <= k_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      st_q    <= st_d;
    end
  end

  always_comb begin
    eng_rst = '1;
    if (state_q == S_RUN) eng_rst[op_idx] = 1'b0;
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_x      = rx_q;
  assign rsp_y      = ry_q;
  assign rsp_status = st_q;
  assign opnd_ax    = ax_q;
  assign opnd_ay    = ay_q;
  assign opnd_bx    = bx_q;
  assign opnd_by    = by_q;
  assign opnd_k     = k_q;

endmodule

// File: tb/tb_ecc_op_dispatcher.sv
// Bench for ecc_op_dispatcher: engine models, scoreboard, scenario tasks.
// Timeout scenarios run when ECC_DISPATCH_TIMEOUT_EN is defined.
module tb_ecc_op_dispatcher;
  import ecc_op_dispatcher_pkg::*;

  localparam int W  = 256;
  localparam int NO = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          cfg_wr_en, cfg_wr_err;
  logic [3:0]    cfg_addr;
  logic [W-1:0]  cfg_wdata;
  logic [W-1:0]  cfg_p, cfg_a, cfg_b, cfg_n, cfg_gx, cfg_gy;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [W-1:0]  cmd_ax, cmd_ay, cmd_bx, cmd_by, cmd_k;
  logic [W-1:0]  opnd_ax, opnd_ay, opnd_bx, opnd_by, opnd_k;
  logic [NO-1:0] eng_rst, eng_done;
  logic [NO*W-1:0] eng_res_x, eng_res_y;
  logic          rsp_valid, rsp_ready, busy;
  logic [W-1:0]  rsp_x, rsp_y;
  logic [1:0]    rsp_status;

  ecc_op_dispatcher #(
    .WIDTH(W), .NUM_OPS(NO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_wr_err(cfg_wr_err),
    .cfg_p(cfg_p), .cfg_a(cfg_a), .cfg_b(cfg_b),
    .cfg_n(cfg_n), .cfg_gx(cfg_gx), .cfg_gy(cfg_gy),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ax(cmd_ax), .cmd_ay(cmd_ay),
    .cmd_bx(cmd_bx), .cmd_by(cmd_by), .cmd_k(cmd_k),
    .opnd_ax(opnd_ax), .opnd_ay(opnd_ay), .opnd_bx(opnd_bx),
    .opnd_by(opnd_by), .opnd_k(opnd_k),
    .eng_rst(eng_rst), .eng_done(eng_done),
    .eng_res_x(eng_res_x), .eng_res_y(eng_res_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_x(rsp_x), .rsp_y(rsp_y),
    .rsp_status(rsp_status), .busy(busy)
  );

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [1:0]   st;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int elat[NO] = '{default: 0};
  int ecnt[NO] = '{default: 0};
  logic [NO-1:0] noise = '0;
  logic [W-1:0] cfg_m[6];

  localparam logic [W-1:0] N_VAL =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;

  function automatic logic [W-1:0] f_x(input logic [1:0] op,
      input logic [W-1:0] ax, input logic [W-1:0] bx,
      input logic [W-1:0] k);
    case (op)
      2'd0:    return k ^ ax;
      2'd1:    return ax + bx;
      2'd2:    return ax * bx;
      default: return ~ax;
    endcase
  endfunction

  function automatic logic [W-1:0] f_y(input logic [1:0] op,
      input logic [W-1:0] ay, input logic [W-1:0] by,
      input logic [W-1:0] k);
    case (op)
      2'd0:    return ay ^ k;
      2'd1:    return ay + by;
      default: return 256'hDEAD;
    endcase
  endfunction

  // Engine models: done after elat[i] cycles out of reset; elat=0 never
  always @(posedge clk)
    for (int i = 0; i < NO; i++)
      ecnt[i] <= eng_rst[i] ? 0 : ecnt[i] + 1;

  always_comb begin
    for (int i = 0; i < NO; i++) begin
      eng_done[i] = noise[i] |
        (!eng_rst[i] && elat[i] > 0 && ecnt[i] == elat[i] - 1);
      eng_res_x[i*W +: W] = f_x(2'(i), opnd_ax, opnd_bx, opnd_k);
      eng_res_y[i*W +: W] = f_y(2'(i), opnd_ay, opnd_by, opnd_k);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_cmd(input logic [1:0] op,
      input logic [W-1:0] ax, input logic [W-1:0] ay,
      input logic [W-1:0] bx, input logic [W-1:0] by,
      input logic [W-1:0] k, input bit tmo);
    exp_t e;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_ax = ax; cmd_ay = ay;
    cmd_bx = bx; cmd_by = by;
    cmd_k = k;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    acc_cyc = cyc;
    e.x = tmo ? '0 : f_x(op, ax, bx, k);
    e.y = (tmo || op >= 2) ? '0 : f_y(op, ay, by, k);
    e.st = tmo ? ST_TIMEOUT : ST_OK;
    q.push_back(e);
  endtask

  task automatic collect_rsp(input int exp_lat, input int budget);
    exp_t e;
    int n = 0;
    while (!rsp_valid && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (!rsp_valid) begin
      errors++;
      $display("FAIL rsp_wait: no rsp_valid in %0d cycles", budget);
      q.delete();
      return;
    end
    checks++;
    if (exp_lat > 0 && cyc - acc_cyc + 1 != exp_lat) begin
      errors++;
      $display("FAIL rsp_latency: got %0d want %0d",
               cyc - acc_cyc + 1, exp_lat);
    end
    checks++;
    if (eng_rst !== 4'b1111) begin
      errors++;
      $display("FAIL eng_rst_resp: got %b want 1111", eng_rst);
    end
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got response, want none");
    end else begin
      e = q.pop_front();
      if (rsp_x !== e.x || rsp_y !== e.y || rsp_status !== e.st) begin
        errors++;
        $display("FAIL rsp_data: got x=%h y=%h st=%b want x=%h y=%h st=%b",
                 rsp_x, rsp_y, rsp_status, e.x, e.y, e.st);
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rsp_release: got valid=%b ready=%b want 0 1",
               rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) cfg_m[i] = '0;
    #3;
    checks++;
    if (eng_rst !== 4'b1111 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
        cfg_wr_err !== 1'b0 || rsp_status !== 2'b00) begin
      errors++;
      $display("FAIL reset_ctrl: got rst=%b v=%b busy=%b err=%b st=%b want 1111 0 0 0 00",
               eng_rst, rsp_valid, busy, cfg_wr_err, rsp_status);
    end
    checks++;
    if ({cfg_p, cfg_a, cfg_b, cfg_n, cfg_gx, cfg_gy, opnd_ax, opnd_k,
         rsp_x, rsp_y} !== '0) begin
      errors++;
      $display("FAIL reset_data: got nonzero cfg/opnd/rsp want 0");
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b busy=%b want 1 0",
               cmd_ready, busy);
    end
  endtask

  task automatic test_cfg_write();
    cfg_wr_en = 1'b1;
    cfg_addr = CFG_N;
    cfg_wdata = N_VAL;
    tick();
    cfg_wr_en = 1'b0;
    cfg_m[3] = N_VAL;
    checks++;
    if (cfg_n !== N_VAL || cfg_wr_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_n_write: got n=%h err=%b want %h 0",
               cfg_n, cfg_wr_err, N_VAL);
    end
    for (int i = 0; i < 6; i++) begin
      if (i == 3) continue;
      cfg_wr_en = 1'b1;
      cfg_addr = 4'(i);
      cfg_wdata = {$urandom, $urandom, 192'h0, 32'(i) + 32'h100};
      cfg_m[i] = cfg_wdata;
      tick();
    end
    cfg_wr_en = 1'b0;
    checks++;
    if ({cfg_p, cfg_a, cfg_b, cfg_n, cfg_gx, cfg_gy} !==
        {cfg_m[0], cfg_m[1], cfg_m[2], cfg_m[3], cfg_m[4], cfg_m[5]}) begin
      errors++;
      $display("FAIL cfg_all: got p=%h gy=%h want p=%h gy=%h",
               cfg_p, cfg_gy, cfg_m[0], cfg_m[5]);
    end
  endtask

  task automatic test_mmul_latency();
    exp_t e;
    logic [3:0] er;
    elat[2] = 10;
    rsp_ready = 1'b0;
    send_cmd(2'd2, 256'd3, 256'd7, 256'd5, 256'd9, 256'd11, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      er = (c >= 2 && c <= 11) ? 4'b1011 : 4'b1111;
      checks++;
      if (eng_rst !== er || rsp_valid !== (c == 12)) begin
        errors++;
        $display("FAIL mmul_cycle%0d: got rst=%b v=%b want %b %b",
                 c, eng_rst, rsp_valid, er, c == 12);
      end
      if (c < 12) tick();
    end
    e = q.pop_front();
    checks++;
    if (rsp_x !== 256'd15 || rsp_y !== '0 || rsp_status !== ST_OK ||
        e.x !== 256'd15) begin
      errors++;
      $display("FAIL mmul_rsp: got x=%h y=%h st=%b want 15 0 00",
               rsp_x, rsp_y, rsp_status);
    end
    for (int h = 0; h < 5; h++) begin
      if (h == 1) begin
        cmd_valid = 1'b1;
        cmd_op = 2'd1;
        cmd_ax = 256'h77;
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_x !== e.x || rsp_y !== e.y ||
          cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL resp_hold%0d: got v=%b x=%h rdy=%b want 1 %h 0",
                 h, rsp_valid, rsp_x, cmd_ready, e.x);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 ||
        opnd_ax !== 256'd3) begin
      errors++;
      $display("FAIL resp_release: got v=%b busy=%b rdy=%b ax=%h want 0 0 1 3",
               rsp_valid, busy, cmd_ready, opnd_ax);
    end
  endtask

  task automatic test_back_to_back();
    elat[0] = 1;
    elat[1] = 1;
    noise = 4'b1110;
    send_cmd(2'd0, 256'hA5, 256'h5A, 256'h11, 256'h22, 256'hF0F0, 1'b0);
    collect_rsp(3, 20);
    noise = 4'b1101;
    send_cmd(2'd1, 256'h1234, 256'h10, 256'h1, 256'h20, 256'h0, 1'b0);
    collect_rsp(3, 20);
    noise = '0;
  endtask

  task automatic test_cfg_lock();
    elat[1] = 20;
    cfg_wr_en = 1'b1;
    cfg_addr = CFG_A;
    cfg_wdata = 256'hA1A1;
    send_cmd(2'd1, 256'h40, 256'h41, 256'h42, 256'h43, 256'h44, 1'b0);
    cfg_wr_en = 1'b0;
    cfg_m[1] = 256'hA1A1;
    checks++;
    if (cfg_a !== 256'hA1A1 || cfg_wr_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_accept_cycle: got a=%h err=%b want a1a1 0",
               cfg_a, cfg_wr_err);
    end
    tick();
    tick();
    cfg_wr_en = 1'b1;
    cfg_addr = CFG_P;
    cfg_wdata = 256'hBAD;
    tick();
    cfg_wr_en = 1'b0;
    checks++;
    if (cfg_wr_err !== 1'b1 || cfg_p !== cfg_m[0]) begin
      errors++;
      $display("FAIL cfg_locked: got err=%b p=%h want 1 %h",
               cfg_wr_err, cfg_p, cfg_m[0]);
    end
    tick();
    checks++;
    if (cfg_wr_err !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_pulse: got %b want 0", cfg_wr_err);
    end
    collect_rsp(22, 60);
    for (int a = 6; a <= 7; a++) begin
      cfg_wr_en = 1'b1;
      cfg_addr = 4'(a);
      cfg_wdata = 256'hBAD0;
      tick();
      cfg_wr_en = 1'b0;
      checks++;
      if (cfg_wr_err !== 1'b1 ||
          {cfg_p, cfg_a, cfg_b, cfg_n, cfg_gx, cfg_gy} !==
          {cfg_m[0], cfg_m[1], cfg_m[2], cfg_m[3], cfg_m[4], cfg_m[5]}) begin
        errors++;
        $display("FAIL cfg_bad_addr%0d: got err=%b want 1, regs unchanged",
                 a, cfg_wr_err);
      end
      tick();
      checks++;
      if (cfg_wr_err !== 1'b0) begin
        errors++;
        $display("FAIL cfg_bad_pulse%0d: got %b want 0", a, cfg_wr_err);
      end
    end
  endtask

  task automatic test_timeout();
`ifdef ECC_DISPATCH_TIMEOUT_EN
    elat[0] = 0;
    send_cmd(2'd0, 256'h9, 256'h8, 256'h7, 256'h6, 256'h5, 1'b1);
    collect_rsp(TO + 2, 60);
    elat[0] = TO;
    send_cmd(2'd0, 256'h19, 256'h18, 256'h17, 256'h16, 256'h15, 1'b0);
    collect_rsp(TO + 2, 60);
`else
    elat[3] = 40;
    send_cmd(2'd3, 256'h3C, 256'h1, 256'h2, 256'h3, 256'h4, 1'b0);
    collect_rsp(42, 100);
`endif
  endtask

  task automatic test_reset_mid_run();
    int seen = 0;
    elat[0] = 0;
    send_cmd(2'd0, 256'hC0, 256'hC1, 256'hC2, 256'hC3, 256'hC4, 1'b0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (eng_rst !== 4'b1111 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_ctrl: got rst=%b v=%b busy=%b want 1111 0 0",
               eng_rst, rsp_valid, busy);
    end
    checks++;
    if ({cfg_p, cfg_a, cfg_b, cfg_n, cfg_gx, cfg_gy} !== '0) begin
      errors++;
      $display("FAIL midrun_cfg: got n=%h a=%h want 0", cfg_n, cfg_a);
    end
    q.delete();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rsp_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrun_norsp: got %0d rsp_valid cycles want 0", seen);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_wr_en = 1'b0;
    cfg_addr = '0;
    cfg_wdata = '0;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_ax = '0; cmd_ay = '0;
    cmd_bx = '0; cmd_by = '0;
    cmd_k = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_cfg_write();
    test_mmul_latency();
    test_back_to_back();
    test_cfg_lock();
    test_timeout();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
